button_event_ctrl: RTL and testbench

//   Gesture controller behind the debounced push-button output. It classifies press

---
 rtl/button_event_ctrl.sv | 141 ++++++++++++++
 tb/tb_button_event_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_ctrl.sv
// Gesture classifier for a debounced active-low button: SHORT, DOUBLE, LONG and REPEAT
// events handed to the consumer through a one-entry valid/ready slot.
module button_event_ctrl #(
  parameter int CLK_FREQ      = 50_000_000,
  parameter int LONG_PRESS_MS = 1000,
  parameter int DOUBLE_GAP_MS = 300,
  parameter int REPEAT_MS     = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       btn_n,
  output logic       event_valid,
  output logic [1:0] event_code,
  input  logic       event_ready,
  output logic       held,
  output logic       event_lost
);

  localparam int LONG_C = (CLK_FREQ / 1000) * LONG_PRESS_MS;
  localparam int GAP_C  = (CLK_FREQ / 1000) * DOUBLE_GAP_MS;
  localparam int REP_C  = (CLK_FREQ / 1000) * REPEAT_MS;
  localparam int MAX_LG = (LONG_C > GAP_C) ? LONG_C : GAP_C;
  localparam int MAX_C  = (MAX_LG > REP_C) ? MAX_LG : REP_C;
  localparam int CNT_W  = $clog2(MAX_C + 1);

  localparam logic [CNT_W-1:0] LONG_END = CNT_W'(LONG_C - 1);
  localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(GAP_C - 1);
  localparam logic [CNT_W-1:0] REP_END  = CNT_W'(REP_C - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  localparam logic [1:0] EV_SHORT  = 2'b00;
  localparam logic [1:0] EV_DOUBLE = 2'b01;
  localparam logic [1:0] EV_LONG   = 2'b10;
  localparam logic [1:0] EV_REPEAT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS1,
    S_WAIT2,
    S_PRESS2,
    S_LONG_HELD
  } state_t;

  state_t           state;
  state_t           nxt_state;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clr;
  logic             gen;
  logic [1:0]       gen_code;
  logic             pressed;

  assign pressed = ~btn_n;

  // Release is tested before any timeout so it always wins a same-cycle tie.
  always_comb begin
    nxt_state = state;
    cnt_clr   = 1'b0;
    gen       = 1'b0;
    gen_code  = EV_SHORT;
    if (!enable) begin
      nxt_state = S_IDLE;
      cnt_clr   = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (pressed) nxt_state = S_PRESS1;
        end
        S_PRESS1: begin
          if (!pressed) begin
            nxt_state = S_WAIT2;
          end else if (cnt == LONG_END) begin
            gen       = 1'b1;
            gen_code  = EV_LONG;
            nxt_state = S_LONG_HELD;
          end
        end
        S_WAIT2: begin
          if (pressed) begin
            nxt_state = S_PRESS2;
          end else if (cnt == GAP_END) begin
            gen       = 1'b1;
            gen_code  = EV_SHORT;
            nxt_state = S_IDLE;
          end
        end
        S_PRESS2: begin
          if (!pressed) begin
            gen       = 1'b1;
            gen_code  = EV_DOUBLE;
            nxt_state = S_IDLE;
          end
        end
        S_LONG_HELD: begin
          if (!pressed) begin
            nxt_state = S_IDLE;
          end else if (cnt == REP_END) begin
            gen      = 1'b1;
            gen_code = EV_REPEAT;
            cnt_clr  = 1'b1;
          end
        end
        default: begin
          nxt_state = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      event_valid <= 1'b0;
      event_code  <= EV_SHORT;
      held        <= 1'b0;
      event_lost  <= 1'b0;
    end else begin
      state <= nxt_state;
      if (cnt_clr || (nxt_state != state)) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
      held       <= enable && (state == S_LONG_HELD);
      event_lost <= 1'b0;
      // A consumer handshake in the same cycle frees the slot for the new event.
      if (gen) begin
        if (!event_valid || event_ready) begin
          event_valid <= 1'b1;
          event_code  <= gen_code;
        end else begin
          event_lost <= 1'b1;
        end
      end else if (event_valid && event_ready) begin
        event_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Bench for button_event_ctrl: directed gesture scenarios plus random button activity,
// all compared every cycle against a timestamp-based gesture model.
module tb_button_event_ctrl;

  localparam int LONG_C = 10;
  localparam int GAP_C  = 5;
  localparam int REP_C  = 4;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       btn_n;
  logic       event_valid;
  logic [1:0] event_code;
  logic       event_ready;
  logic       held;
  logic       event_lost;

  int n_tests;
  int n_fail;

  // Reference model: presses counted in the current gesture, whether the button is
  // down, whether the gesture became a long hold, and when the current phase began.
  int         m_presses;
  bit         m_down;
  bit         m_long;
  int         m_since;
  int         cyc;
  logic       m_valid;
  logic [1:0] m_code;
  logic       m_held;
  logic       m_lost;

  button_event_ctrl #(
    .CLK_FREQ      (1000),
    .LONG_PRESS_MS (10),
    .DOUBLE_GAP_MS (5),
    .REPEAT_MS     (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .btn_n       (btn_n),
    .event_valid (event_valid),
    .event_code  (event_code),
    .event_ready (event_ready),
    .held        (held),
    .event_lost  (event_lost)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_step(input logic rn, input logic en, input logic pressed,
                            input logic rdy);
    logic       gen;
    logic [1:0] code;
    logic       was_long;
    if (!rn) begin
      m_presses = 0; m_down = 0; m_long = 0; m_since = cyc;
      m_valid = 0; m_code = 2'b00; m_held = 0; m_lost = 0;
      return;
    end
    gen = 0;
    code = 2'b00;
    was_long = m_long;
    if (!en) begin
      m_presses = 0; m_down = 0; m_long = 0;
    end else if (m_presses == 0) begin
      if (pressed) begin
        m_presses = 1; m_down = 1; m_since = cyc;
      end
    end else if (m_long) begin
      if (!pressed) begin
        m_presses = 0; m_down = 0; m_long = 0;
      end else if (cyc - m_since == REP_C) begin
        gen = 1; code = 2'b11; m_since = cyc;
      end
    end else if (m_down) begin
      if (!pressed) begin
        if (m_presses == 2) begin
          gen = 1; code = 2'b01; m_presses = 0; m_down = 0;
        end else begin
          m_down = 0; m_since = cyc;
        end
      end else if (m_presses == 1 && cyc - m_since == LONG_C) begin
        gen = 1; code = 2'b10; m_long = 1; m_since = cyc;
      end
    end else begin
      if (pressed) begin
        m_presses = 2; m_down = 1; m_since = cyc;
      end else if (cyc - m_since == GAP_C) begin
        gen = 1; code = 2'b00; m_presses = 0;
      end
    end
    m_held = en && was_long;
    m_lost = 0;
    if (gen) begin
      if (!m_valid || rdy) begin
        m_valid = 1; m_code = code;
      end else begin
        m_lost = 1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
  endtask

  task automatic tick(input logic rn, input logic en, input logic b, input logic rdy);
    rst_n = rn; enable = en; btn_n = b; event_ready = rdy;
    @(posedge clk);
    model_step(rn, en, !b, rdy);
    cyc++;
    @(negedge clk);
    check("model_valid", event_valid, m_valid);
    check("model_code", event_code, m_code);
    check("model_held", held, m_held);
    check("model_lost", event_lost, m_lost);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) tick(1, 1, 1, rdy);
  endtask

  initial begin
    int lost_cnt;
    n_tests = 0; n_fail = 0; cyc = 0;
    m_presses = 0; m_down = 0; m_long = 0; m_since = 0;
    m_valid = 0; m_code = 0; m_held = 0; m_lost = 0;
    rst_n = 0; enable = 1; btn_n = 1; event_ready = 1;

    // Reset with the button held, then a short press
    for (int i = 0; i < 3; i++) tick(0, 1, 0, 1);
    check("rst_valid", event_valid, 0);
    check("rst_held", held, 0);
    check("rst_lost", event_lost, 0);
    idle(1, 1);
    for (int i = 0; i < 3; i++) tick(1, 1, 0, 1);
    tick(1, 1, 1, 1);
    for (int i = 0; i < 4; i++) begin
      tick(1, 1, 1, 1);
      check("t1_no_early_short", event_valid, 0);
    end
    tick(1, 1, 1, 1);
    check("t1_short_valid", event_valid, 1);
    check("t1_short_code", event_code, 2'b00);
    idle(3, 1);

    // Double press
    for (int i = 0; i < 3; i++) tick(1, 1, 0, 1);
    for (int i = 0; i < 2; i++) tick(1, 1, 1, 1);
    for (int i = 0; i < 3; i++) begin
      tick(1, 1, 0, 1);
      check("t2_no_event_yet", event_valid, 0);
    end
    tick(1, 1, 1, 1);
    check("t2_double_valid", event_valid, 1);
    check("t2_double_code", event_code, 2'b01);
    for (int i = 0; i < 8; i++) begin
      tick(1, 1, 1, 1);
      check("t2_no_short", event_valid, 0);
    end

    // Long hold with repeats
    for (int i = 0; i < 20; i++) begin
      tick(1, 1, 0, 1);
      check("t3_valid", event_valid, (i == 10 || i == 14 || i == 18));
      if (i == 10) check("t3_long_code", event_code, 2'b10);
      if (i == 14 || i == 18) check("t3_repeat_code", event_code, 2'b11);
      check("t3_held", held, (i >= 11));
    end
    tick(1, 1, 1, 1);
    check("t3_held_after_release", held, 1);
    for (int i = 0; i < 6; i++) begin
      tick(1, 1, 1, 1);
      check("t3_released_held", held, 0);
      check("t3_no_more_events", event_valid, 0);
    end

    // Backpressure: SHORT pending, LONG dropped
    for (int i = 0; i < 2; i++) tick(1, 1, 0, 0);
    tick(1, 1, 1, 0);
    for (int i = 0; i < 5; i++) tick(1, 1, 1, 0);
    check("t4_short_pending", event_valid, 1);
    check("t4_short_code", event_code, 2'b00);
    lost_cnt = 0;
    for (int i = 0; i < 11; i++) begin
      tick(1, 1, 0, 0);
      lost_cnt += int'(event_lost);
      check("t4_code_stable", event_code, 2'b00);
    end
    tick(1, 1, 1, 0);
    lost_cnt += int'(event_lost);
    for (int i = 0; i < 3; i++) begin
      tick(1, 1, 1, 0);
      lost_cnt += int'(event_lost);
    end
    check("t4_lost_once", lost_cnt, 1);
    check("t4_still_valid", event_valid, 1);
    tick(1, 1, 1, 1);
    check("t4_drop_after_ready", event_valid, 0);
    idle(2, 1);

    // Boundary: release exactly at the long threshold, press exactly at the gap limit
    tick(1, 1, 0, 1);
    for (int i = 0; i < 9; i++) tick(1, 1, 0, 1);
    tick(1, 1, 1, 1);
    check("t5_no_long", event_valid, 0);
    check("t5_no_held", held, 0);
    for (int i = 0; i < 4; i++) tick(1, 1, 1, 1);
    tick(1, 1, 0, 1);
    check("t5_no_short", event_valid, 0);
    for (int i = 0; i < 2; i++) tick(1, 1, 0, 1);
    tick(1, 1, 1, 1);
    check("t5_double_valid", event_valid, 1);
    check("t5_double_code", event_code, 2'b01);
    idle(8, 1);

    // enable dropped mid-press with an event pending
    for (int i = 0; i < 2; i++) tick(1, 1, 0, 0);
    for (int i = 0; i < 6; i++) tick(1, 1, 1, 0);
    for (int i = 0; i < 4; i++) tick(1, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      tick(1, 0, 0, 0);
      check("t6_pending_kept", event_valid, 1);
    end
    for (int i = 0; i <= 10; i++) begin
      tick(1, 1, 0, (i >= 2));
      if (i < 2) check("t6_pending_code", event_code, 2'b00);
      check("t6_valid", event_valid, (i < 2 || i == 10));
      if (i == 10) check("t6_long_code", event_code, 2'b10);
    end
    tick(1, 1, 1, 1);
    idle(4, 1);

    // Random activity against the model
    for (int s = 0; s < 160; s++) begin
      int   len;
      logic b;
      logic en;
      len = $urandom_range(1, 16);
      b   = 1'($urandom_range(0, 1));
      en  = ($urandom_range(0, 19) != 0);
      for (int i = 0; i < len; i++) begin
        tick(($urandom_range(0, 299) != 0), en, b, ($urandom_range(0, 3) != 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
